// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline hold/flush sequencing for load-use, mispredict and multi-cycle M-type hazards
module pipe_hazard_ctrl #(
    parameter int MUL_LAT = 3,
    parameter logic [4:0] OP_LOAD = 5'b00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IM_stall,
    input  logic        DM_stall,
    input  logic [4:0]  D_rs1,
    input  logic [4:0]  D_rs2,
    input  logic        D_uses_rs1,
    input  logic        D_uses_rs2,
    input  logic [4:0]  E_op,
    input  logic [4:0]  E_rd,
    input  logic        E_is_mtype,
    input  logic        E_mispredict,
    output logic        F_hold,
    output logic        D_hold,
    output logic        D_flush,
    output logic        E_hold,
    output logic        E_flush,
    output logic        M_bubble,
    output logic        mul_busy,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
);
    typedef enum logic {IDLE, BUSY} state_t;
    localparam logic [3:0] CNT_INIT = 4'(MUL_LAT > 1 ? MUL_LAT - 2 : 0);
    localparam logic MUL_MULTI = MUL_LAT > 1;
    state_t state;
    logic [3:0] cnt;
    logic freeze, idle, load_use, mis, mul_start, busy_hold, lu, hold;
    always_comb begin
        freeze    = IM_stall | DM_stall;
        idle      = state == IDLE;
        load_use  = (E_op == OP_LOAD) && (E_rd != 5'd0) &&
                    ((D_uses_rs1 && D_rs1 == E_rd) || (D_uses_rs2 && D_rs2 == E_rd));
        mis       = !rst && !freeze && idle && E_mispredict;
        mul_start = !rst && !freeze && idle && !E_mispredict && E_is_mtype && MUL_MULTI;
        busy_hold = !rst && !freeze && !idle && cnt != 4'd0;
        lu        = !rst && !freeze && idle && !E_mispredict && !(E_is_mtype && MUL_MULTI) && load_use;
        hold      = mul_start | busy_hold;
        F_hold    = hold | lu;
        D_hold    = hold | lu;
        D_flush   = mis;
        E_hold    = hold;
        E_flush   = mis | lu;
        M_bubble  = hold;
        mul_busy  = !rst && !idle;
    end
    // Frozen cycles leave every piece of state untouched so occupancy stretches 1:1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            stall_cycles <= 32'd0;
            flush_events <= 32'd0;
        end else if (!freeze) begin
            if (mul_start) begin
                state <= BUSY;
                cnt   <= CNT_INIT;
            end else if (busy_hold) begin
                cnt <= cnt - 4'd1;
            end else if (!idle) begin
                state <= IDLE;
            end
            stall_cycles <= stall_cycles + {31'd0, F_hold};
            flush_events <= flush_events + {31'd0, mis};
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for pipe_hazard_ctrl (MUL_LAT=3 and MUL_LAT=1 instances)
module tb_pipe_hazard_ctrl;
    logic clk = 0, rst = 1;
    logic IM_stall, DM_stall, D_uses_rs1, D_uses_rs2, E_is_mtype, E_mispredict;
    logic [4:0] D_rs1, D_rs2, E_op, E_rd;
    logic F_hold, D_hold, D_flush, E_hold, E_flush, M_bubble, mul_busy;
    logic [31:0] stall_cycles, flush_events;
    logic F1, D1, Df1, E1, Ef1, M1, b1;
    logic [31:0] sc1, fe1;
    int errors = 0, checks = 0;
    typedef struct {
        string tag;
        logic [6:0] c;
        logic [6:0] c1;
        logic [31:0] st;
        logic [31:0] fl;
    } exp_t;
    exp_t q[$];
    localparam logic [6:0] Z = 7'b0000000, LU = 7'b1100100, MP = 7'b0010100,
                           MS = 7'b1101010, MB = 7'b1101011, MR = 7'b0000001;

    pipe_hazard_ctrl #(.MUL_LAT(3)) dut (
        .clk(clk), .rst(rst), .IM_stall(IM_stall), .DM_stall(DM_stall),
        .D_rs1(D_rs1), .D_rs2(D_rs2), .D_uses_rs1(D_uses_rs1), .D_uses_rs2(D_uses_rs2),
        .E_op(E_op), .E_rd(E_rd), .E_is_mtype(E_is_mtype), .E_mispredict(E_mispredict),
        .F_hold(F_hold), .D_hold(D_hold), .D_flush(D_flush), .E_hold(E_hold),
        .E_flush(E_flush), .M_bubble(M_bubble), .mul_busy(mul_busy),
        .stall_cycles(stall_cycles), .flush_events(flush_events));

    pipe_hazard_ctrl #(.MUL_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .IM_stall(IM_stall), .DM_stall(DM_stall),
        .D_rs1(D_rs1), .D_rs2(D_rs2), .D_uses_rs1(D_uses_rs1), .D_uses_rs2(D_uses_rs2),
        .E_op(E_op), .E_rd(E_rd), .E_is_mtype(E_is_mtype), .E_mispredict(E_mispredict),
        .F_hold(F1), .D_hold(D1), .D_flush(Df1), .E_hold(E1),
        .E_flush(Ef1), .M_bubble(M1), .mul_busy(b1),
        .stall_cycles(sc1), .flush_events(fe1));

    always #5 clk = ~clk;

    function automatic logic [6:0] ctrl();
        return {F_hold, D_hold, D_flush, E_hold, E_flush, M_bubble, mul_busy};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear();
        IM_stall = 0; DM_stall = 0; D_rs1 = 0; D_rs2 = 0; D_uses_rs1 = 0; D_uses_rs2 = 0;
        E_op = 5'h0C; E_rd = 0; E_is_mtype = 0; E_mispredict = 0;
    endtask

    task automatic load(input logic [4:0] rd);
        E_op = 5'b00000; E_rd = rd;
    endtask

    task automatic step(input string tag, input logic [6:0] c, input logic [6:0] c1,
                        input logic [31:0] st, input logic [31:0] fl);
        exp_t e;
        q.push_back('{tag, c, c1, st, fl});
        @(negedge clk);
        e = q.pop_front();
        check({e.tag, "_ctrl"}, {25'd0, ctrl()}, {25'd0, e.c});
        check({e.tag, "_ctrl1"}, {25'd0, F1, D1, Df1, E1, Ef1, M1, b1}, {25'd0, e.c1});
        check({e.tag, "_stall"}, stall_cycles, e.st);
        check({e.tag, "_flush"}, flush_events, e.fl);
        @(posedge clk); #1;
    endtask

    initial begin
        clear();
        @(negedge clk);
        check("reset_ctrl", {25'd0, ctrl()}, 32'd0);
        check("reset_stall", stall_cycles, 32'd0);
        check("reset_flush", flush_events, 32'd0);
        @(posedge clk); #1 rst = 0;
        load(5); D_rs2 = 5; D_uses_rs2 = 1;  step("lu_rs2", LU, LU, 0, 0);
        clear();                             step("lu_after", Z, Z, 1, 0);
        load(0); D_rs2 = 0; D_uses_rs2 = 1;  step("lu_rd0", Z, Z, 1, 0);
        clear(); load(5); D_rs2 = 5;         step("lu_nouse", Z, Z, 1, 0);
        clear(); load(7); D_rs1 = 7; D_uses_rs1 = 1; step("lu_rs1", LU, LU, 1, 0);
        clear(); E_mispredict = 1;           step("mis", MP, MP, 2, 0);
        clear();                             step("mis_after", Z, Z, 2, 1);
        E_is_mtype = 1;                      step("mul_c1", MS, Z, 2, 1);
                                             step("mul_c2", MB, Z, 3, 1);
                                             step("mul_c3", MR, Z, 4, 1);
                                             step("mul2_c1", MS, Z, 4, 1);
        DM_stall = 1;
        for (int i = 0; i < 4; i++)          step("frz_busy", MR, Z, 5, 1);
        DM_stall = 0;                        step("mul2_c2", MB, Z, 5, 1);
                                             step("mul2_c3", MR, Z, 6, 1);
        clear();                             step("mul_done", Z, Z, 6, 1);
        IM_stall = 1; E_mispredict = 1;
        for (int i = 0; i < 2; i++)          step("frz_mis", Z, Z, 6, 1);
        IM_stall = 0;                        step("mis_late", MP, MP, 6, 1);
        clear();                             step("mis_late_after", Z, Z, 6, 2);
        E_is_mtype = 1;                      step("rst_mul_c1", MS, Z, 6, 2);
        check("busy_before_rst", {31'd0, mul_busy}, 32'd1);
        #2 rst = 1;
        #1;
        check("arst_ctrl", {25'd0, ctrl()}, 32'd0);
        check("arst_stall", stall_cycles, 32'd0);
        check("arst_flush", flush_events, 32'd0);
        @(posedge clk); #3 rst = 0;
        clear(); @(posedge clk); #1;
        E_mispredict = 1;                    step("post_rst_mis", MP, MP, 0, 0);
        clear(); load(9); D_rs2 = 9; D_uses_rs2 = 1; step("post_rst_lu", LU, LU, 0, 1);
        clear();                             step("post_rst_end", Z, Z, 1, 1);
        check("sb_empty", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
